mips_multicycle_datapath: RTL and testbench

// - Multicycle MIPS-subset core: datapath plus internal control FSM sharing one ALU and one

---
 rtl/mips_multicycle_datapath.sv | 201 ++++++++++++++++++++
 tb/tb_mips_multicycle_datapath.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_datapath.sv
// Multicycle MIPS-subset core: one shared ALU, one unified memory port, internal control FSM.
// Optional build macro MC_BNE_EN: decode bne (opcode 000101) as a branch taken when rs != rt.
module mips_multicycle_datapath #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  instr_done,
  output logic                  illegal,
  output logic [3:0]            state_dbg
);

  // Memory handshake: mem_req, mem_we, mem_addr and mem_wdata hold steady from the first
  // requesting cycle until a cycle with mem_ready=1, which completes the access (rdata sampled then).

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t                state, state_nx;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] mdr, a_reg, b_reg, alu_out;
  logic [DATA_WIDTH-1:0] regs [32];

  logic [5:0]            opcode, funct;
  logic [4:0]            rs, rt, rd;
  logic [DATA_WIDTH-1:0] sext_imm, rf_rs, rf_rt;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_res;
  logic [2:0]            alu_ctl, funct_ctl;
  logic                  funct_ok, alu_zero, br_taken, retire;
  logic [31:0]           jump_full;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign sext_imm = {{(DATA_WIDTH-16){ir[15]}}, ir[15:0]};
  assign rf_rs    = (rs == 5'd0) ? '0 : regs[rs];
  assign rf_rt    = (rt == 5'd0) ? '0 : regs[rt];

  // Jump keeps the top nibble of the already-incremented PC.
  assign jump_full = (32'(pc) & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};

  assign mem_req   = reset & ((state == S_FETCH) | (state == S_MEMRD) | (state == S_MEMWR));
  assign mem_we    = reset & (state == S_MEMWR);
  assign mem_addr  = (state == S_FETCH) ? pc : alu_out[ADDR_WIDTH-1:0];
  assign mem_wdata = b_reg;
  assign state_dbg = state;

  always_comb begin
    funct_ok  = 1'b1;
    funct_ctl = ALU_ADD;
    case (funct)
      6'b100000: funct_ctl = ALU_ADD;
      6'b100010: funct_ctl = ALU_SUB;
      6'b100100: funct_ctl = ALU_AND;
      6'b100101: funct_ctl = ALU_OR;
      6'b101010: funct_ctl = ALU_SLT;
      default:   funct_ok  = 1'b0;
    endcase
  end

  // Operand steering for the single shared ALU.
  always_comb begin
    alu_a   = a_reg;
    alu_b   = b_reg;
    alu_ctl = ALU_ADD;
    case (state)
      S_FETCH: begin
        alu_a = DATA_WIDTH'(pc);
        alu_b = DATA_WIDTH'(32'd4);
      end
      S_DECODE: begin
        alu_a = DATA_WIDTH'(pc);
        alu_b = sext_imm << 2;
      end
      S_MEMADR, S_ADDIEX: alu_b   = sext_imm;
      S_EXEC:             alu_ctl = funct_ctl;
      S_BRANCH:           alu_ctl = ALU_SUB;
      default: ;
    endcase
  end

  always_comb begin
    case (alu_ctl)
      ALU_ADD: alu_res = alu_a + alu_b;
      ALU_SUB: alu_res = alu_a - alu_b;
      ALU_AND: alu_res = alu_a & alu_b;
      ALU_OR:  alu_res = alu_a | alu_b;
      ALU_SLT: alu_res = DATA_WIDTH'($signed(alu_a) < $signed(alu_b));
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

`ifdef MC_BNE_EN
  assign br_taken = (opcode == OP_BNE) ? ~alu_zero : alu_zero;
`else
  assign br_taken = alu_zero;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:  if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_RTYPE:     state_nx = S_EXEC;
          OP_BEQ:       state_nx = S_BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_nx = S_BRANCH;
`endif
          OP_ADDI:      state_nx = S_ADDIEX;
          OP_J:         state_nx = S_JUMP;
          default:      state_nx = S_HALT;
        endcase
      end
      S_MEMADR: state_nx = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_nx = S_FETCH;
      S_EXEC:   state_nx = funct_ok ? S_ALUWB : S_HALT;
      S_ADDIEX: state_nx = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_nx = S_FETCH;
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_HALT;
    endcase
  end

  assign retire = (state == S_MEMWB) | (state == S_ALUWB) | (state == S_BRANCH) |
                  (state == S_ADDIWB) | (state == S_JUMP) | ((state == S_MEMWR) & mem_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      mdr        <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      alu_out    <= '0;
      instr_done <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state      <= state_nx;
      instr_done <= retire;
      if (state_nx == S_HALT) illegal <= 1'b1;
      case (state)
        S_FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata[31:0];
            pc <= alu_res[ADDR_WIDTH-1:0];
          end
        end
        S_DECODE: begin
          a_reg   <= rf_rs;
          b_reg   <= rf_rt;
          alu_out <= alu_res;
        end
        S_MEMADR, S_ADDIEX, S_EXEC: alu_out <= alu_res;
        S_MEMRD:  if (mem_ready) mdr <= mem_rdata;
        S_MEMWB:  if (rt != 5'd0) regs[rt] <= mdr;
        S_ALUWB:  if (rd != 5'd0) regs[rd] <= alu_out;
        S_ADDIWB: if (rt != 5'd0) regs[rt] <= alu_out;
        S_BRANCH: if (br_taken) pc <= alu_out[ADDR_WIDTH-1:0];
        S_JUMP:   pc <= ADDR_WIDTH'(jump_full);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Directed-vector bench for mips_multicycle_datapath: small programs in a bench memory,
// register results observed through stores, plus stall and reset corner sequences.
module tb_mips_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        instr_done, illegal;
  logic [3:0]  state_dbg;

  logic        ready_en = 1'b0;
  logic        block_wr = 1'b0;
  logic [31:0] mem      [64];
  logic [31:0] load_img [64];
  logic [31:0] wr_log_a [8];
  logic [31:0] wr_log_d [8];
  int          wr_cnt;

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  mips_multicycle_datapath dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
  );

  // Clock / reset-side memory model.
  always #5 clk = ~clk;

  assign mem_ready = mem_req & ready_en & ~(mem_we & block_wr);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= load_img[i];
      wr_cnt <= 0;
    end else if (mem_req && mem_we && mem_ready) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      if (wr_cnt < 8) begin
        wr_log_a[wr_cnt] <= mem_addr;
        wr_log_d[wr_cnt] <= mem_wdata;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Instruction encoders.
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs_f,
                                        input logic [4:0] rt_f, input logic [15:0] imm);
    return {op, rs_f, rt_f, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                        input logic [4:0] rd_f, input logic [5:0] fn);
    return {6'b000000, rs_f, rt_f, rd_f, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'b000010, tgt};
  endfunction

  typedef struct packed {
    logic [5:0][31:0] prog;
    int               n_ret;
    int               exp_cyc;
    logic [31:0]      exp_pc;
    int               n_wr;
    logic [1:0][31:0] wr_addr;
    logic [1:0][31:0] wr_data;
    bit               exp_ill;
  } vec_t;

  vec_t vecs [12];
  int   nv = 0;

  task automatic add_vec(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                         input logic [31:0] p3, input logic [31:0] p4, input logic [31:0] p5,
                         input int n_ret, input int cyc, input logic [31:0] epc, input int n_wr,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic [31:0] a1, input logic [31:0] d1, input bit ill);
    vec_t t;
    t.prog[0] = p0; t.prog[1] = p1; t.prog[2] = p2;
    t.prog[3] = p3; t.prog[4] = p4; t.prog[5] = p5;
    t.n_ret   = n_ret;
    t.exp_cyc = cyc;
    t.exp_pc  = epc;
    t.n_wr    = n_wr;
    t.wr_addr[0] = a0; t.wr_data[0] = d0;
    t.wr_addr[1] = a1; t.wr_data[1] = d1;
    t.exp_ill = ill;
    vecs[nv]  = t;
    nv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: hold reset across an edge (loads memory), then release on a falling edge.
  task automatic apply_reset(input logic [5:0][31:0] prog, input bit rdy);
    reset    = 1'b0;
    ready_en = rdy;
    block_wr = 1'b0;
    for (int i = 0; i < 64; i++) load_img[i] = 32'h0;
    for (int i = 0; i < 6; i++) load_img[i] = prog[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_until(input int n, output int cyc);
    int done_cnt;
    done_cnt = 0;
    cyc = 0;
    while (done_cnt < n && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (instr_done) done_cnt++;
    end
    chk("retire timeout", 32'(done_cnt), 32'(n));
  endtask

  localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  initial begin
    int          cyc;
    int          w;
    logic [63:0] e;
    logic [5:0][31:0] p;

    // Vectors: {program, retires, cycles to last retire, pc then, writes, illegal}.
    add_vec(enc_i(OP_ADDI,0,1,16'd5), enc_i(OP_ADDI,0,2,16'd7), enc_r(1,2,3,F_ADD), 0, 0, 0,
            3, 12, 32'h0C, 0, 0, 0, 0, 0, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'd5), enc_i(OP_ADDI,0,2,16'd7), enc_r(1,2,3,F_ADD),
            enc_i(OP_SW,0,3,16'd8), enc_i(OP_LW,0,4,16'd8), enc_i(OP_SW,0,4,16'd12),
            6, 25, 32'h18, 2, 32'd8, 32'd12, 32'd12, 32'd12, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'd3), enc_i(OP_ADDI,0,2,16'd4), enc_r(1,2,0,F_ADD),
            enc_i(OP_SW,0,0,16'd16), 0, 0,
            4, 16, 32'h10, 1, 32'd16, 32'd0, 0, 0, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'hFFFD), enc_i(OP_ADDI,0,2,16'd6), enc_r(1,2,3,F_SLT),
            enc_r(2,1,4,F_SUB), enc_i(OP_SW,0,3,16'd64), enc_i(OP_SW,0,4,16'd68),
            6, 24, 32'h18, 2, 32'd64, 32'd1, 32'd68, 32'd9, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'h0F0F), enc_i(OP_ADDI,0,2,16'h00FF), enc_r(1,2,3,F_AND),
            enc_r(1,2,4,F_OR), enc_i(OP_SW,0,3,16'd64), enc_i(OP_SW,0,4,16'd68),
            6, 24, 32'h18, 2, 32'd64, 32'h0000000F, 32'd68, 32'h00000FFF, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'hFFFD), enc_i(OP_ADDI,0,2,16'd6), enc_r(2,1,3,F_SLT),
            enc_r(1,1,4,F_ADD), enc_i(OP_SW,0,3,16'd64), enc_i(OP_SW,0,4,16'd68),
            6, 24, 32'h18, 2, 32'd64, 32'd0, 32'd68, 32'hFFFFFFFA, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'd1), enc_i(OP_ADDI,0,2,16'd2), enc_i(OP_ADDI,0,3,16'd3),
            enc_i(OP_SW,0,1,16'd64), enc_i(OP_BEQ,1,1,16'hFFFE), 0,
            5, 19, 32'h0C, 1, 32'd64, 32'd1, 0, 0, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'd1), enc_i(OP_BEQ,1,0,16'd5), enc_j(26'h40), 0, 0, 0,
            3, 10, 32'h100, 0, 0, 0, 0, 0, 0);
    add_vec(enc_i(OP_ADDI,0,1,16'd1), 32'hFC000000, 0, 0, 0, 0,
            1, 4, 32'h04, 0, 0, 0, 0, 0, 1);
    add_vec(enc_i(OP_ADDI,0,1,16'd1), 32'h0000003F, 0, 0, 0, 0,
            1, 4, 32'h04, 0, 0, 0, 0, 0, 1);
`ifdef MC_BNE_EN
    add_vec(enc_i(OP_ADDI,0,1,16'd1), enc_i(OP_BNE,1,2,16'd1), enc_i(OP_ADDI,0,5,16'd5), 0, 0, 0,
            2, 7, 32'h0C, 0, 0, 0, 0, 0, 0);
`else
    add_vec(enc_i(OP_ADDI,0,1,16'd1), enc_i(OP_BNE,1,2,16'd1), enc_i(OP_ADDI,0,5,16'd5), 0, 0, 0,
            1, 4, 32'h04, 0, 0, 0, 0, 0, 1);
`endif

    // Reset state.
    for (int i = 0; i < 64; i++) load_img[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset instr_done", 32'(instr_done), 32'd0);
    chk("reset illegal", 32'(illegal), 32'd0);
    chk("reset pc", pc, 32'h0);

    for (int v = 0; v < nv; v++) begin
      apply_reset(vecs[v].prog, 1'b1);
      exp_q.delete();
      for (int k = 0; k < vecs[v].n_wr; k++)
        exp_q.push_back({vecs[v].wr_addr[k], vecs[v].wr_data[k]});
      run_until(vecs[v].n_ret, cyc);
      chk($sformatf("v%0d cycles", v), 32'(cyc), 32'(vecs[v].exp_cyc));
      chk($sformatf("v%0d pc", v), pc, vecs[v].exp_pc);
      chk($sformatf("v%0d write count", v), 32'(wr_cnt), 32'(vecs[v].n_wr));
      for (int k = 0; k < wr_cnt && k < 8; k++) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk($sformatf("v%0d wr%0d addr", v, k), wr_log_a[k], e[63:32]);
          chk($sformatf("v%0d wr%0d data", v, k), wr_log_d[k], e[31:0]);
        end
      end
      if (vecs[v].exp_ill) begin
        w = 0;
        while (!illegal && w < 8) begin
          @(posedge clk);
          #1;
          w++;
        end
        chk($sformatf("v%0d illegal set", v), 32'(illegal), 32'd1);
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          #1;
          chk($sformatf("v%0d halted req", v), {31'd0, mem_req}, 32'd0);
          chk($sformatf("v%0d halted illegal", v), {31'd0, illegal}, 32'd1);
        end
      end else begin
        chk($sformatf("v%0d illegal", v), 32'(illegal), 32'd0);
      end
    end

    // Fetch stall: three cycles without mem_ready keep the request steady and pc put.
    p = '0;
    p[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    apply_reset(p, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall%0d req", k), 32'(mem_req), 32'd1);
      chk($sformatf("stall%0d addr", k), mem_addr, 32'h0);
      chk($sformatf("stall%0d pc", k), pc, 32'h0);
    end
    ready_en = 1'b1;
    run_until(1, cyc);
    chk("stall latency", 32'(cyc + 3), 32'd7);

    // Asynchronous reset in the middle of a store that memory never acknowledges.
    p = '0;
    p[0] = enc_i(OP_ADDI, 0, 1, 16'd9);
    p[1] = enc_i(OP_SW, 0, 1, 16'd4);
    apply_reset(p, 1'b1);
    block_wr = 1'b1;
    w = 0;
    while (!(mem_req && mem_we) && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("memwr reached", 32'(mem_req && mem_we), 32'd1);
    chk("memwr wdata", mem_wdata, 32'd9);
    chk("memwr addr", mem_addr, 32'd4);
    #1;
    reset = 1'b0;
    #1;
    chk("async reset req", 32'(mem_req), 32'd0);
    chk("async reset we", 32'(mem_we), 32'd0);
    chk("async reset pc", pc, 32'h0);
    chk("async reset state", 32'(state_dbg), 32'd0);
    block_wr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
